// File: rtl/mealy_sync_tx.sv
// Serial frame transmitter: sync word, MSB-first payload, optional even parity, then idle-high gap.
// Define MEALY_SYNC_TX_PARITY_EN to append the even-parity bit after the payload.
module mealy_sync_tx #(
  parameter int unsigned        DATA_W       = 8,
  parameter int unsigned        SYNC_W       = 4,
  parameter logic [SYNC_W-1:0]  SYNC_PATTERN = SYNC_W'(4'b0100),
  parameter int unsigned        GAP          = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              busy,
  output logic              x,
  output logic              done
);

  localparam int unsigned MAX_SD  = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int unsigned MAX_ALL = (MAX_SD > GAP) ? MAX_SD : GAP;
  localparam int unsigned CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP);
  localparam logic [CNT_W-1:0] GAP_READY = CNT_W'(GAP - 1);

`ifdef MEALY_SYNC_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_PAR, S_GAP} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_GAP} state_e;
`endif

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                x_q, x_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                enter_gap;
  logic                load;
  logic [SYNC_W-1:0]   sync_sh;
`ifdef MEALY_SYNC_TX_PARITY_EN
  logic                par_q, par_d;
`endif

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      x_q     <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MEALY_SYNC_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      x_q     <= x_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MEALY_SYNC_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // NOTE: every signal gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    x_d       = 1'b1;
    ready_d   = ready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    enter_gap = 1'b0;
    load      = 1'b0;
    sync_sh   = SYNC_PATTERN << (cnt_q + 1'b1);
`ifdef MEALY_SYNC_TX_PARITY_EN
    par_d     = par_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        load    = start;
      end
      S_SYNC: begin
        if (cnt_q == SYNC_LAST) begin
          state_d = S_DATA;
          cnt_d   = '0;
          x_d     = shift_q[DATA_W-1];
          shift_d = shift_q << 1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          x_d   = sync_sh[SYNC_W-1];
        end
      end
      S_DATA: begin
        if (cnt_q == DATA_LAST) begin
`ifdef MEALY_SYNC_TX_PARITY_EN
          state_d = S_PAR;
          x_d     = par_q;
`else
          enter_gap = 1'b1;
`endif
        end else begin
          cnt_d   = cnt_q + 1'b1;
          x_d     = shift_q[DATA_W-1];
          shift_d = shift_q << 1;
        end
      end
`ifdef MEALY_SYNC_TX_PARITY_EN
      S_PAR: enter_gap = 1'b1;
`endif
      S_GAP: begin
        // The gap's final edge doubles as the next accept edge for back-to-back frames.
        if (cnt_q == GAP_LAST) begin
          if (start && ready_q) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == GAP_READY) ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_gap) begin
      state_d = S_GAP;
      cnt_d   = CNT_W'(1);
      x_d     = 1'b1;
      done_d  = 1'b1;
      ready_d = (GAP == 1);
    end

    if (load) begin
      state_d = S_SYNC;
      cnt_d   = '0;
      shift_d = data;
      x_d     = SYNC_PATTERN[SYNC_W-1];
      ready_d = 1'b0;
      busy_d  = 1'b1;
`ifdef MEALY_SYNC_TX_PARITY_EN
      par_d   = ^data;
`endif
    end
  end

  assign x     = x_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_mealy_sync_tx.sv
// Directed bench for mealy_sync_tx with default parameters; follows MEALY_SYNC_TX_PARITY_EN if defined.
module tb_mealy_sync_tx;

  localparam int DW = 8;
`ifdef MEALY_SYNC_TX_PARITY_EN
  localparam int L = 4 + DW + 1;
`else
  localparam int L = 4 + DW;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] data;
  logic          ready, busy, x, done;
  int            checks = 0;
  int            failures = 0;

  mealy_sync_tx dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .data  (data),
    .ready (ready),
    .busy  (busy),
    .x     (x),
    .done  (done)
  );

  always #5 clk = ~clk;

  function automatic logic [L-1:0] frame_bits(input logic [DW-1:0] d);
`ifdef MEALY_SYNC_TX_PARITY_EN
    return {4'b0100, d, ^d};
`else
    return {4'b0100, d};
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic [3:0] want);
    checks++;
    if ({x, ready, busy, done} !== want) begin
      failures++;
      $display("FAIL %s {x,ready,busy,done}: got %b want %b", tag, {x, ready, busy, done}, want);
    end
  endtask

  // Entered in the cycle after the accept edge; leaves in the gap cycle.
  task automatic expect_frame(input logic [DW-1:0] d, input string tag, input bit hold_next);
    logic [L-1:0] f;
    f = frame_bits(d);
    for (int k = 0; k < L; k++) begin
      checks++;
      if (x !== f[L-1-k]) begin
        failures++;
        $display("FAIL %s bit %0d x: got %b want %b", tag, k, x, f[L-1-k]);
      end
      checks++;
      if ({ready, busy, done} !== 3'b010) begin
        failures++;
        $display("FAIL %s bit %0d {ready,busy,done}: got %b want 010", tag, k, {ready, busy, done});
      end
      if (hold_next) begin
        if (k == 2) start = 1'b0;
        if (k == 5) start = 1'b1;
        if (k == 6) start = 1'b0;
        if (k == L-1) start = 1'b1;
      end
      tick();
    end
    check_flags({tag, "_gap"}, 4'b1111);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    check_flags("reset_async", 4'b1100);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_flags("reset_idle", 4'b1100);
    end
  endtask

  task automatic test_single(input logic [DW-1:0] d, input string tag);
    data  = d;
    start = 1'b1;
    tick();
    start = 1'b0;
    data  = ~d;
    expect_frame(d, tag, 1'b0);
    tick();
    check_flags({tag, "_idle0"}, 4'b1100);
    tick();
    check_flags({tag, "_idle1"}, 4'b1100);
  endtask

  task automatic test_back_to_back;
    data  = 8'hFF;
    start = 1'b1;
    tick();
    data  = 8'h00;
    expect_frame(8'hFF, "b2b_first", 1'b1);
    tick();
    start = 1'b0;
    expect_frame(8'h00, "b2b_second", 1'b0);
    tick();
    check_flags("b2b_idle", 4'b1100);
  endtask

  task automatic test_reset_mid;
    data  = 8'h5A;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check_flags("mid_bit6", 4'b0010);
    rst = 1'b1;
    #1;
    check_flags("mid_rst_async", 4'b1100);
    tick();
    check_flags("mid_rst_held", 4'b1100);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_flags("mid_after_release", 4'b1100);
    end
    test_single(8'hA5, "after_rst");
  endtask

  task automatic test_loopback;
    logic [3:0] hist;
    int         hits;
    int         at;
    hist = 4'b1111;
    hits = 0;
    at   = -1;
    data  = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < L + 2; k++) begin
      hist = {hist[2:0], x};
      if (hist == 4'b0100) begin
        hits++;
        at = k;
      end
      tick();
    end
    checks++;
    if (hits != 1) begin
      failures++;
      $display("FAIL loopback hit count: got %0d want 1", hits);
    end
    checks++;
    if (at != 3) begin
      failures++;
      $display("FAIL loopback hit position: got %0d want 3", at);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    data  = '0;
    test_reset();
    test_single(8'hA5, "single_a5");
    test_single(8'h07, "single_07");
    test_back_to_back();
    test_reset_mid();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
